uart_rx_sampler: RTL

Receive front-end of the UART echo path. Synchronises the asynchronous `rx` pin, recovers 8N1 frames by 16x oversampling with a 3-sample majority vote, and queues received bytes in a 4-entry FIFO. The FIFO's valid/ready interface feeds the downstream buffering/transmit stage. Clock is 12 MHz; the baud select encoding matches the rest of the UART blocks.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_rx_sampler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: baud encodings, 16x oversampling divisors for a 12 MHz clock,
// and the receiver state encoding.
package uart_pkg;

    localparam logic [1:0] BAUD_110  = 2'b00;
    localparam logic [1:0] BAUD_600  = 2'b01;
    localparam logic [1:0] BAUD_2400 = 2'b10;
    localparam logic [1:0] BAUD_9600 = 2'b11;

    localparam int unsigned OVS_RATE     = 16;
    localparam int unsigned PRESC_W      = 20;
    localparam int unsigned OVS_DIV_110  = 6818;
    localparam int unsigned OVS_DIV_600  = 1250;
    localparam int unsigned OVS_DIV_2400 = 312;
    localparam int unsigned OVS_DIV_9600 = 78;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Oversampling tick divisor for a baud select code.
    function automatic logic [PRESC_W-1:0] baud_div(input logic [1:0] sel);
        case (sel)
            BAUD_110:  baud_div = PRESC_W'(OVS_DIV_110);
            BAUD_600:  baud_div = PRESC_W'(OVS_DIV_600);
            BAUD_2400: baud_div = PRESC_W'(OVS_DIV_2400);
            default:   baud_div = PRESC_W'(OVS_DIV_9600);
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; pointers carry one extra wrap bit so full/empty need no flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + CW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front-end: rx synchroniser, 16x oversampling 8N1 framer with
// 3-sample majority vote, and a show-ahead byte queue.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_HZ     = 12000000
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [1:0]                   baud,
    input  logic                         rx,
    output logic [7:0]                   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         overrun
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("uart_rx_sampler: FIFO_DEPTH must be a power of two >= 2");
    end
    if (CLK_HZ != 12000000) begin : g_clk_chk
        $warning("uart_rx_sampler: baud divisors assume a 12 MHz clock");
    end

    rx_state_t          state;
    rx_state_t          state_nxt;
    logic               rx_meta;
    logic               rxs;
    logic               rxs_prev;
    logic [1:0]         sync_vld;
    logic               armed;
    logic [PRESC_W-1:0] div_q;
    logic [PRESC_W-1:0] presc;
    logic [3:0]         phase;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               s7;
    logic               s8;
    logic               tick_c;
    logic               start_c;
    logic               maj_c;
    logic               push_c;
    logic               ferr_c;
    logic               pop_c;
    logic               fifo_full;
    logic               fifo_empty;

    // Synchroniser; start detection is armed only once a genuine high has passed
    // through the chain, so rx held low across reset release is not a start.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | (sync_vld[1] & rxs);
        end
    end

    assign start_c = (state == IDLE) & armed & rxs_prev & ~rxs;
    assign tick_c  = (state != IDLE) && (presc == div_q - PRESC_W'(1));
    assign maj_c   = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
    assign pop_c   = out_ready & ~fifo_empty;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_c    = 1'b0;
        ferr_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start_c) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (tick_c && (phase == 4'd9) && maj_c) begin
                    state_nxt = IDLE;
                end else if (tick_c && (phase == 4'd15)) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick_c && (phase == 4'd15) && (bit_cnt == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge is caught early.
                if (tick_c && (phase == 4'd9)) begin
                    state_nxt = IDLE;
                    push_c    = maj_c;
                    ferr_c    = ~maj_c;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Prescaler, bit phase, majority samples and shift register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q     <= '0;
            presc     <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                div_q <= baud_div(baud);
            end
            if ((state == IDLE) || tick_c) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
            if (start_c) begin
                phase   <= '0;
                bit_cnt <= '0;
            end else if (tick_c) begin
                phase <= phase + 4'd1;
                if (phase == 4'd7) begin
                    s7 <= rxs;
                end
                if (phase == 4'd8) begin
                    s8 <= rxs;
                end
                if ((state == DATA) && (phase == 4'd9)) begin
                    shreg <= {maj_c, shreg[7:1]};
                end
                if ((state == DATA) && (phase == 4'd15)) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            busy      <= (state_nxt != IDLE);
            frame_err <= ferr_c;
            overrun   <= push_c & fifo_full & ~pop_c;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push_c),
        .push_data (shreg),
        .pop       (out_ready),
        .head      (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = ~fifo_empty;

endmodule
